// File: rtl/key_debouncer_if.sv
// Key debouncer signal bundle: sampling strobe and raw key in, debounced level and
// press/release strobes out.
interface key_debouncer_if;
    logic sample_en;
    logic key_in;
    logic key_out;
    logic press_pulse;
    logic release_pulse;

    modport master (
        output sample_en,
        output key_in,
        input  key_out,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  sample_en,
        input  key_in,
        output key_out,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/key_debouncer.sv
// Active-low push-button debouncer: synchronizer plus stable-sample counter filter.
// Define DEBOUNCE_PULSE_EN to drive the registered press/release strobes; otherwise they tie to 0.
module key_debouncer #(
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    key_debouncer_if.slave bus
);

    localparam int unsigned CntW = $clog2(STABLE_SAMPLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_sync;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   key_q, key_d;

    assign key_sync = sync_q[SYNC_STAGES-1];

    // Synchronizer runs every clk, independent of the sampling strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.key_in};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        key_d = key_q;
        if (key_sync == key_q) begin
            cnt_d = '0;
        end else if (bus.sample_en) begin
            if (cnt_q == CntW'(STABLE_SAMPLES - 1)) begin
                key_d = key_sync;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            key_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            key_q <= key_d;
        end
    end

    assign bus.key_out = key_q;

`ifdef DEBOUNCE_PULSE_EN
    logic press_q, release_q;

    // Strobes are set on the same edge key_out moves, so they coincide with its first new cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= key_q & ~key_d;
            release_q <= ~key_q & key_d;
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
`else
    assign bus.press_pulse   = 1'b0;
    assign bus.release_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: STABLE_SAMPLES=4, SYNC_STAGES=2, sample_en 1 clk in 8.
module tb_key_debouncer;

`ifdef DEBOUNCE_PULSE_EN
    localparam logic PulseEn = 1'b1;
`else
    localparam logic PulseEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    key_debouncer_if bus ();

    key_debouncer #(
        .STABLE_SAMPLES(4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int phase     = 0;
    int press_cnt = 0;
    int rel_cnt   = 0;
    int p0        = 0;
    int r0        = 0;
    logic both_seen  = 1'b0;
    logic bounce_bad = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk: drive the strobe for the coming edge, then sample 1 time unit after it.
    task automatic cyc();
        bus.sample_en = (phase == 7);
        phase = (phase + 1) % 8;
        @(posedge clk);
        #1;
        if (bus.press_pulse === 1'b1) press_cnt++;
        if (bus.release_pulse === 1'b1) rel_cnt++;
        if (bus.press_pulse === 1'b1 && bus.release_pulse === 1'b1) both_seen = 1'b1;
    endtask

    task automatic periods(input int n);
        repeat (n * 8) cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.key_in = 1'b0;
        bus.sample_en = 1'b0;

        // Reset held 3 clk with the key pressed.
        repeat (3) cyc();
        check("rst_key_out", {7'd0, bus.key_out}, 8'd1);
        check("rst_press", {7'd0, bus.press_pulse}, 8'd0);
        check("rst_release", {7'd0, bus.release_pulse}, 8'd0);
        check("rst_cnt", 8'(dut.cnt_q), 8'd0);
        check("rst_sync", 8'(dut.sync_q), 8'd3);
        rst_n = 1'b1;
        phase = 0;
        press_cnt = 0;
        rel_cnt = 0;
        periods(3);
        check("rst_after3_key", {7'd0, bus.key_out}, 8'd1);
        check("rst_after3_cnt", 8'(dut.cnt_q), 8'd3);
        periods(1);
        check("rst_after4_key", {7'd0, bus.key_out}, 8'd0);
        check("rst_after4_press", {7'd0, bus.press_pulse}, {7'd0, PulseEn});

        // Release from pressed.
        bus.key_in = 1'b1;
        p0 = press_cnt;
        r0 = rel_cnt;
        periods(3);
        check("rel1_after3_key", {7'd0, bus.key_out}, 8'd0);
        periods(1);
        check("rel1_after4_key", {7'd0, bus.key_out}, 8'd1);
        check("rel1_pulse", {7'd0, bus.release_pulse}, {7'd0, PulseEn});
        periods(1);
        check("rel1_rel_count", 8'(rel_cnt - r0), {7'd0, PulseEn});
        check("rel1_press_count", 8'(press_cnt - p0), 8'd0);

        // Clean press held ~50 clk.
        bus.key_in = 1'b0;
        p0 = press_cnt;
        periods(3);
        check("press_after3_key", {7'd0, bus.key_out}, 8'd1);
        periods(1);
        check("press_after4_key", {7'd0, bus.key_out}, 8'd0);
        check("press_pulse", {7'd0, bus.press_pulse}, {7'd0, PulseEn});
        periods(2);
        check("press_hold_key", {7'd0, bus.key_out}, 8'd0);
        check("press_count", 8'(press_cnt - p0), {7'd0, PulseEn});

        // Release again; press strobe must stay quiet.
        bus.key_in = 1'b1;
        p0 = press_cnt;
        r0 = rel_cnt;
        periods(4);
        check("rel2_key", {7'd0, bus.key_out}, 8'd1);
        periods(1);
        check("rel2_rel_count", 8'(rel_cnt - r0), {7'd0, PulseEn});
        check("rel2_press_count", 8'(press_cnt - p0), 8'd0);

        // Bounce: toggle every 5 clk for 40 clk, then settle low.
        p0 = press_cnt;
        for (int i = 0; i < 40; i++) begin
            bus.key_in = ((i / 5) % 2) != 0;
            cyc();
            if (bus.key_out !== 1'b1) bounce_bad = 1'b1;
        end
        check("bounce_key_held", {7'd0, bounce_bad}, 8'd0);
        check("bounce_no_press", 8'(press_cnt - p0), 8'd0);
        bus.key_in = 1'b0;
        periods(3);
        check("bounce_settle3_key", {7'd0, bus.key_out}, 8'd1);
        periods(1);
        check("bounce_settle4_key", {7'd0, bus.key_out}, 8'd0);
        periods(1);
        check("bounce_press_count", 8'(press_cnt - p0), {7'd0, PulseEn});

        bus.key_in = 1'b1;
        periods(5);
        check("rel3_key", {7'd0, bus.key_out}, 8'd1);

        // Short glitch: low for 3 ticks only.
        p0 = press_cnt;
        r0 = rel_cnt;
        bus.key_in = 1'b0;
        periods(3);
        check("glitch_cnt3", 8'(dut.cnt_q), 8'd3);
        check("glitch_key_low3", {7'd0, bus.key_out}, 8'd1);
        bus.key_in = 1'b1;
        periods(1);
        check("glitch_cnt_clear", 8'(dut.cnt_q), 8'd0);
        check("glitch_key", {7'd0, bus.key_out}, 8'd1);
        check("glitch_pulses", 8'((press_cnt - p0) + (rel_cnt - r0)), 8'd0);

        // Reset in the middle of filtering discards the press.
        bus.key_in = 1'b0;
        periods(2);
        check("mid_cnt2", 8'(dut.cnt_q), 8'd2);
        rst_n = 1'b0;
        cyc();
        check("mid_rst_cnt", 8'(dut.cnt_q), 8'd0);
        check("mid_rst_key", {7'd0, bus.key_out}, 8'd1);
        check("mid_rst_sync", 8'(dut.sync_q), 8'd3);
        rst_n = 1'b1;
        phase = 0;
        p0 = press_cnt;
        periods(3);
        check("mid_after3_key", {7'd0, bus.key_out}, 8'd1);
        check("mid_after3_cnt", 8'(dut.cnt_q), 8'd3);
        periods(1);
        check("mid_after4_key", {7'd0, bus.key_out}, 8'd0);
        check("mid_press", {7'd0, bus.press_pulse}, {7'd0, PulseEn});

        check("pulses_never_together", {7'd0, both_seen}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
